pipelined_csa_add_sub: RTL and testbench



---
 rtl/pipelined_csa_add_sub_pkg.sv | 28 ++
 rtl/pipelined_csa_add_sub_if.sv | 28 ++
 rtl/csa_block.sv | 32 +++
 rtl/pipelined_csa_add_sub.sv | 155 +++++++++++++++
 tb/tb_pipelined_csa_add_sub.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_csa_add_sub_pkg.sv
// Shared defaults and signed-limit helpers for the pipelined carry-select add/sub unit.
package pipelined_csa_add_sub_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 16;
    localparam int unsigned DEFAULT_BLOCK_WIDTH = 2;
    localparam int unsigned MAX_WIDTH           = 64;

    // Most positive two's-complement value of the given width, zero-extended to MAX_WIDTH.
    function automatic logic [MAX_WIDTH-1:0] signed_max(input int unsigned width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i + 1 < width) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Most negative two's-complement value of the given width, zero-extended to MAX_WIDTH.
    function automatic logic [MAX_WIDTH-1:0] signed_min(input int unsigned width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i + 1 == width) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pipelined_csa_add_sub_if.sv
// Operand/result handshake bundle; master drives operands and out_ready, slave is the adder.
interface pipelined_csa_add_sub_if
    import pipelined_csa_add_sub_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, overflow
    );

endinterface

// File: rtl/csa_block.sv
// One carry-select slice: two ripple adders (carry-in 0 and 1) with a 2:1 select on the real carry.
module csa_block #(
    parameter int unsigned BLOCK_WIDTH = 2
) (
    input  logic [BLOCK_WIDTH-1:0] x_i,
    input  logic [BLOCK_WIDTH-1:0] y_i,
    input  logic                   cin_i,
    output logic [BLOCK_WIDTH-1:0] sum_o,
    output logic                   cout_o
);

    logic [BLOCK_WIDTH-1:0] sum0, sum1;
    logic [BLOCK_WIDTH:0]   c0, c1;

    always_comb begin
        sum0  = '0;
        sum1  = '0;
        c0    = '0;
        c1    = '0;
        c1[0] = 1'b1;
        for (int unsigned i = 0; i < BLOCK_WIDTH; i++) begin
            sum0[i]  = x_i[i] ^ y_i[i] ^ c0[i];
            c0[i+1]  = (x_i[i] & y_i[i]) | (c0[i] & (x_i[i] ^ y_i[i]));
            sum1[i]  = x_i[i] ^ y_i[i] ^ c1[i];
            c1[i+1]  = (x_i[i] & y_i[i]) | (c1[i] & (x_i[i] ^ y_i[i]));
        end
    end

    assign sum_o  = cin_i ? sum1 : sum0;
    assign cout_o = cin_i ? c1[BLOCK_WIDTH] : c0[BLOCK_WIDTH];

endmodule

// File: rtl/pipelined_csa_add_sub.sv
// Two-stage carry-select adder/subtractor: low half in stage 1, high half plus overflow and
// optional saturation in stage 2, with valid/ready flow control on both ends.
module pipelined_csa_add_sub
    import pipelined_csa_add_sub_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH,
    parameter bit          SATURATE    = 1'b1
) (
    input logic                    clk,
    input logic                    rst_n,
    pipelined_csa_add_sub_if.slave bus
);

    localparam int unsigned HALF = DATA_WIDTH / 2;
    localparam int unsigned NBLK = HALF / BLOCK_WIDTH;
    localparam logic [DATA_WIDTH-1:0] SMAX = DATA_WIDTH'(signed_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SMIN = DATA_WIDTH'(signed_min(DATA_WIDTH));

    if (DATA_WIDTH % (2 * BLOCK_WIDTH) != 0) begin : g_width_check
        $error("DATA_WIDTH must be a multiple of 2*BLOCK_WIDTH");
    end

    // Stage 1: lower half
    logic [DATA_WIDTH-1:0] bp;
    logic [HALF-1:0]       sum_lo;
    logic [NBLK:0]         carry_lo;

    assign bp          = bus.sub ? ~bus.b : bus.b;
    assign carry_lo[0] = bus.sub;

    for (genvar i = 0; i < NBLK; i++) begin : g_lo
        csa_block #(
            .BLOCK_WIDTH(BLOCK_WIDTH)
        ) u_blk (
            .x_i   (bus.a[i*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .y_i   (bp[i*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .cin_i (carry_lo[i]),
            .sum_o (sum_lo[i*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .cout_o(carry_lo[i+1])
        );
    end

    logic            s1_valid_q, s1_valid_d;
    logic [HALF-1:0] s1_sum_lo_q, s1_sum_lo_d;
    logic            s1_cout_q, s1_cout_d;
    logic [HALF-1:0] s1_a_hi_q, s1_a_hi_d;
    logic [HALF-1:0] s1_bp_hi_q, s1_bp_hi_d;
    logic            s1_sub_q, s1_sub_d;

    // Stage 2: upper half resumes from the registered low-half carry
    logic [HALF-1:0] sum_hi;
    logic [NBLK:0]   carry_hi;

    assign carry_hi[0] = s1_cout_q;

    for (genvar i = 0; i < NBLK; i++) begin : g_hi
        csa_block #(
            .BLOCK_WIDTH(BLOCK_WIDTH)
        ) u_blk (
            .x_i   (s1_a_hi_q[i*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .y_i   (s1_bp_hi_q[i*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .cin_i (carry_hi[i]),
            .sum_o (sum_hi[i*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .cout_o(carry_hi[i+1])
        );
    end

    // Carry out of the MSB is meaningless for signed results; sub travels with the operands
    // for visibility only.
    logic unused_carry_hi;
    logic unused_s1_sub;
    assign unused_carry_hi = carry_hi[NBLK];
    assign unused_s1_sub   = s1_sub_q;

    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  overflow_q, overflow_d;

    logic s1_en, s2_en;
    logic a_msb, bp_msb, raw_msb, ovf;

    assign s2_en = !s2_valid_q || bus.out_ready;
    assign s1_en = !s1_valid_q || s2_en;

    assign a_msb   = s1_a_hi_q[HALF-1];
    assign bp_msb  = s1_bp_hi_q[HALF-1];
    assign raw_msb = sum_hi[HALF-1];
    assign ovf     = (a_msb == bp_msb) && (raw_msb != a_msb);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sum_lo_d = s1_sum_lo_q;
        s1_cout_d   = s1_cout_q;
        s1_a_hi_d   = s1_a_hi_q;
        s1_bp_hi_d  = s1_bp_hi_q;
        s1_sub_d    = s1_sub_q;
        s2_valid_d  = s2_valid_q;
        result_d    = result_q;
        overflow_d  = overflow_q;

        if (s1_en) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_sum_lo_d = sum_lo;
                s1_cout_d   = carry_lo[NBLK];
                s1_a_hi_d   = bus.a[DATA_WIDTH-1:HALF];
                s1_bp_hi_d  = bp[DATA_WIDTH-1:HALF];
                s1_sub_d    = bus.sub;
            end
        end

        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                overflow_d = ovf;
                if (SATURATE && ovf) begin
                    result_d = a_msb ? SMIN : SMAX;
                end else begin
                    result_d = {sum_hi, s1_sum_lo_q};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum_lo_q <= '0;
            s1_cout_q   <= 1'b0;
            s1_a_hi_q   <= '0;
            s1_bp_hi_q  <= '0;
            s1_sub_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_lo_q <= s1_sum_lo_d;
            s1_cout_q   <= s1_cout_d;
            s1_a_hi_q   <= s1_a_hi_d;
            s1_bp_hi_q  <= s1_bp_hi_d;
            s1_sub_q    <= s1_sub_d;
            s2_valid_q  <= s2_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.in_ready  = s1_en;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_pipelined_csa_add_sub.sv
// Randomized + directed bench: saturating and wrapping instances share one stimulus stream and
// are scored against an integer-arithmetic model through per-instance expectation queues.
module tb_pipelined_csa_add_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    pipelined_csa_add_sub_if #(.DATA_WIDTH(16)) bus1 ();
    pipelined_csa_add_sub_if #(.DATA_WIDTH(16)) bus0 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.a         = a;
    assign bus1.b         = b;
    assign bus1.sub       = sub;
    assign bus1.out_ready = out_ready;
    assign bus0.in_valid  = in_valid;
    assign bus0.a         = a;
    assign bus0.b         = b;
    assign bus0.sub       = sub;
    assign bus0.out_ready = out_ready;

    pipelined_csa_add_sub #(
        .DATA_WIDTH (16),
        .BLOCK_WIDTH(2),
        .SATURATE   (1'b1)
    ) u_dut_sat (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    pipelined_csa_add_sub #(
        .DATA_WIDTH (16),
        .BLOCK_WIDTH(2),
        .SATURATE   (1'b0)
    ) u_dut_wrap (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    typedef struct packed {
        logic [15:0] res_sat;
        logic [15:0] res_wrap;
        logic        ovf;
        logic [31:0] cyc;
        logic        lat;
    } exp_t;

    exp_t        q1[$];
    exp_t        q0[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic [31:0] cyc = '0;
    logic        lat_mode = 1'b0;
    logic        fired = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: exact integer result, then wrap or clamp to the signed 16-bit range.
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic sv);
        exp_t e;
        int   sa, sb, exact;
        sa         = int'($signed(av));
        sb         = int'($signed(bv));
        exact      = sv ? sa - sb : sa + sb;
        e          = '0;
        e.ovf      = (exact > 32767) || (exact < -32768);
        e.res_wrap = exact[15:0];
        e.res_sat  = !e.ovf ? exact[15:0] : (exact > 0 ? 16'h7FFF : 16'h8000);
        return e;
    endfunction

    function automatic logic [15:0] rnd_operand();
        case ($urandom_range(7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock: score outputs at the falling edge, record accepted operands, advance.
    task automatic step();
        exp_t e, f;
        @(negedge clk);
        e     = model(a, b, sub);
        e.cyc = cyc;
        e.lat = lat_mode;
        check_eq("in_ready_sat", 32'(bus1.in_ready), 32'(q1.size() < 2 || out_ready));
        check_eq("in_ready_wrap", 32'(bus0.in_ready), 32'(q0.size() < 2 || out_ready));
        if (bus1.out_valid) begin
            if (q1.size() == 0) begin
                check_eq("spurious_sat", 32'(1), 32'(0));
            end else begin
                f = q1[0];
                check_eq("result_sat", 32'(bus1.result), 32'(f.res_sat));
                check_eq("overflow_sat", 32'(bus1.overflow), 32'(f.ovf));
                if (out_ready) begin
                    if (f.lat) check_eq("latency", cyc - f.cyc, 32'(2));
                    void'(q1.pop_front());
                end
            end
        end
        if (bus0.out_valid) begin
            if (q0.size() == 0) begin
                check_eq("spurious_wrap", 32'(1), 32'(0));
            end else begin
                f = q0[0];
                check_eq("result_wrap", 32'(bus0.result), 32'(f.res_wrap));
                check_eq("overflow_wrap", 32'(bus0.overflow), 32'(f.ovf));
                if (out_ready) void'(q0.pop_front());
            end
        end
        fired = in_valid && bus1.in_ready;
        if (fired) q1.push_back(e);
        if (in_valid && bus0.in_ready) q0.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic sv);
        int n;
        n        = 0;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        sub      = sv;
        fired    = 1'b0;
        while (!fired && n < 50) begin
            step();
            n++;
        end
        if (!fired) check_eq("send_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q1.size() != 0 || q0.size() != 0) && n < 20) begin
            step();
            n++;
        end
        check_eq("drain_sat", 32'(q1.size()), 32'(0));
        check_eq("drain_wrap", 32'(q0.size()), 32'(0));
    endtask

    logic [15:0] dir_a[6] = '{16'h7FFF, 16'h0005, 16'h8000, 16'h00FF, 16'h1234, 16'hFFFF};
    logic [15:0] dir_b[6] = '{16'h0001, 16'h8000, 16'h0001, 16'h0001, 16'h1234, 16'h0001};
    logic        dir_s[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int idx, n, accepted;

        // Reset state
        #1;
        check_eq("rst_out_valid", 32'(bus1.out_valid), 32'(0));
        check_eq("rst_in_ready", 32'(bus1.in_ready), 32'(1));
        check_eq("rst_result", 32'(bus1.result), 32'(0));
        check_eq("rst_overflow", 32'(bus1.overflow), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed corner vectors then four random ops, all back-to-back
        lat_mode  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(dir_a[i], dir_b[i], dir_s[i]);
        for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
        drain();
        lat_mode = 1'b0;

        // Backpressure: only two fit while the output is stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        idx       = 0;
        for (int i = 0; i < 3; i++) begin
            a   = dir_a[idx];
            b   = dir_b[idx];
            sub = dir_s[idx];
            step();
            if (fired) idx++;
        end
        check_eq("bp_accepted", 32'(idx), 32'(2));
        check_eq("bp_in_ready", 32'(bus1.in_ready), 32'(0));
        out_ready = 1'b1;
        n         = 0;
        while (idx < 3 && n < 20) begin
            a   = dir_a[idx];
            b   = dir_b[idx];
            sub = dir_s[idx];
            step();
            if (fired) idx++;
            n++;
        end
        check_eq("bp_third", 32'(idx), 32'(3));
        drain();

        // Reset with two operations in flight
        out_ready = 1'b0;
        send(16'h0100, 16'h0200, 1'b0);
        send(16'h0300, 16'h0004, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(bus1.out_valid), 32'(0));
        check_eq("midrst_in_ready", 32'(bus1.in_ready), 32'(1));
        check_eq("midrst_out_valid_wrap", 32'(bus0.out_valid), 32'(0));
        q1.delete();
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("no_stale", 32'(bus1.out_valid), 32'(0));
        end

        // Random traffic with random stalls on both sides
        accepted = 0;
        n        = 0;
        while (accepted < 10000 && n < 40000) begin
            in_valid  = ($urandom_range(3) != 0);
            a         = rnd_operand();
            b         = rnd_operand();
            sub       = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
            step();
            if (fired) accepted++;
            n++;
        end
        check_eq("random_accepted", 32'(accepted), 32'(10000));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
